// File: rtl/n64_vinfo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : n64_vinfo_ctrl
//  Purpose  : Qualifies the extracted {vmode, n64_480i} pair over consecutive
//             frames, runs a req/ack reconfiguration handshake with the
//             mode-dependent stages and keeps them blanked until a mode is
//             committed. Lock drops on a mode change or on loss of nDSYNC.
//  Options  : VINFO_CTRL_ACK_TIMEOUT_EN - abort RECONF after ACK_TO_FRAMES
//             matching frame samples without ack and pulse cfg_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module n64_vinfo_ctrl #(
  parameter int unsigned LOCK_FRAMES   = 4,
  parameter int unsigned ACK_TO_FRAMES = 3
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [3:0] Sync_pre,
  input  logic [3:0] Sync_cur,
  input  logic [3:0] vinfo_i,
  input  logic       cfg_ack_i,
  output logic       vmode_o,
  output logic       n64_480i_o,
  output logic       locked_o,
  output logic       blank_o,
  output logic       cfg_req_o,
  output logic       cfg_err_o
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_RECONF   = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  localparam logic [3:0] C_LOCK_FRAMES = 4'(LOCK_FRAMES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cand;
  logic [1:0] w_cand_nxt;
  logic [1:0] r_commit;
  logic [1:0] w_commit_nxt;
  logic [3:0] r_qcnt;
  logic [3:0] w_qcnt_nxt;
  logic [3:0] w_qinc;
  logic [2:0] r_wd;
  logic       r_smp;
  logic       w_frame_evt;
  logic [1:0] w_mode;
  logic       w_unused_bits;

  // The extractor refreshes vinfo_i on the event cycle, so sampling happens
  // one cycle later. data_cnt bits are not part of the mode.
  assign w_frame_evt = ~nDSYNC & Sync_pre[3] & ~Sync_cur[3];
  assign w_mode      = vinfo_i[1:0];
  assign w_qinc      = (r_qcnt == C_LOCK_FRAMES) ? r_qcnt : r_qcnt + 4'd1;

`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
  localparam logic [3:0] C_ACK_TO_FRAMES = 4'(ACK_TO_FRAMES);

  logic [3:0] r_tcnt;
  logic [3:0] w_tcnt_nxt;
  logic       r_err;
  logic       w_err_nxt;

  assign cfg_err_o     = r_err;
  assign w_unused_bits = ^{vinfo_i[3:2], Sync_pre[2:0], Sync_cur[2:0]};
`else
  assign cfg_err_o     = 1'b0;
  assign w_unused_bits = ^{vinfo_i[3:2], Sync_pre[2:0], Sync_cur[2:0]} ^ (ACK_TO_FRAMES == 0);
`endif

  // Next-state logic: watchdog overrides everything, ack beats smp in RECONF
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_commit_nxt = r_commit;
    w_qcnt_nxt   = r_qcnt;
`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
    w_tcnt_nxt   = r_tcnt;
    w_err_nxt    = 1'b0;
`endif
    if (r_wd == 3'd7) begin
      w_state_nxt = ST_UNLOCKED;
      w_qcnt_nxt  = 4'd0;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (r_smp) begin
            w_cand_nxt = w_mode;
            w_qcnt_nxt = 4'd1;
            if (C_LOCK_FRAMES == 4'd1) begin
              w_state_nxt = ST_RECONF;
`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
              w_tcnt_nxt  = 4'd0;
`endif
            end else begin
              w_state_nxt = ST_QUALIFY;
            end
          end
        end
        ST_QUALIFY: begin
          if (r_smp) begin
            if (w_mode == r_cand) begin
              w_qcnt_nxt = w_qinc;
              if (w_qinc == C_LOCK_FRAMES) begin
                w_state_nxt = ST_RECONF;
`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
                w_tcnt_nxt  = 4'd0;
`endif
              end
            end else begin
              w_cand_nxt = w_mode;
              w_qcnt_nxt = 4'd1;
            end
          end
        end
        ST_RECONF: begin
          if (cfg_ack_i) begin
            w_commit_nxt = r_cand;
            w_state_nxt  = ST_LOCKED;
          end else if (r_smp) begin
            if (w_mode != r_cand) begin
              w_cand_nxt  = w_mode;
              w_qcnt_nxt  = 4'd1;
              w_state_nxt = ST_QUALIFY;
            end
`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
            else begin
              w_tcnt_nxt = r_tcnt + 4'd1;
              if (w_tcnt_nxt == C_ACK_TO_FRAMES) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_UNLOCKED;
              end
            end
`endif
          end
        end
        ST_LOCKED: begin
          if (r_smp && (w_mode != r_commit)) begin
            w_cand_nxt  = w_mode;
            w_qcnt_nxt  = 4'd1;
            w_state_nxt = ST_QUALIFY;
          end
        end
        default: w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // State, candidate, commit and sample-pipeline registers
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      r_state  <= ST_UNLOCKED;
      r_cand   <= 2'd0;
      r_commit <= 2'd0;
      r_qcnt   <= 4'd0;
      r_smp    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_commit <= w_commit_nxt;
      r_qcnt   <= w_qcnt_nxt;
      r_smp    <= w_frame_evt;
    end
  end

  // nDSYNC watchdog; holds at 7 so the unlock persists while sync is absent
  always_ff @(posedge VCLK) begin
    if (!nRST || !nDSYNC) begin
      r_wd <= 3'd0;
    end else if (r_wd != 3'd7) begin
      r_wd <= r_wd + 3'd1;
    end
  end

`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
  // Ack timeout counter and one-cycle error pulse
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      r_tcnt <= 4'd0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_err  <= w_err_nxt;
    end
  end
`endif

  assign vmode_o    = r_commit[1];
  assign n64_480i_o = r_commit[0];
  assign locked_o   = (r_state == ST_LOCKED);
  assign blank_o    = (r_state != ST_LOCKED);
  assign cfg_req_o  = (r_state == ST_RECONF);

endmodule
`default_nettype wire

// File: tb/tb_n64_vinfo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_vinfo_ctrl
//  Purpose  : Self-checking bench for n64_vinfo_ctrl: directed scenarios plus
//             randomized frame streams compared every cycle against a
//             behavioural model of the lock rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n64_vinfo_ctrl;

  localparam int LOCK_FRAMES   = 4;
  localparam int ACK_TO_FRAMES = 3;

  logic       VCLK = 1'b0;
  logic       nRST;
  logic       nDSYNC;
  logic [3:0] Sync_pre;
  logic [3:0] Sync_cur;
  logic [3:0] vinfo_i;
  logic       cfg_ack_i;
  logic       vmode_o;
  logic       n64_480i_o;
  logic       locked_o;
  logic       blank_o;
  logic       cfg_req_o;
  logic       cfg_err_o;

  n64_vinfo_ctrl #(
    .LOCK_FRAMES  (LOCK_FRAMES),
    .ACK_TO_FRAMES(ACK_TO_FRAMES)
  ) u_dut (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .nDSYNC    (nDSYNC),
    .Sync_pre  (Sync_pre),
    .Sync_cur  (Sync_cur),
    .vinfo_i   (vinfo_i),
    .cfg_ack_i (cfg_ack_i),
    .vmode_o   (vmode_o),
    .n64_480i_o(n64_480i_o),
    .locked_o  (locked_o),
    .blank_o   (blank_o),
    .cfg_req_o (cfg_req_o),
    .cfg_err_o (cfg_err_o)
  );

  always #5 VCLK = ~VCLK;

  // Reference model: "run" = length of the current run of identical samples
  // being qualified (0 = idle), plus request/lock flags.
  logic       m_evt_d, m_req, m_locked, m_err;
  logic [1:0] m_cand, m_commit;
  int         m_run, m_waits, m_silent;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_pol  = 0;
  int   req_age  = 0;
  logic saw_req  = 1'b0;
  int   err_seen = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {2'b00, vmode_o, n64_480i_o, locked_o, blank_o, cfg_req_o, cfg_err_o};
  endfunction

  function automatic logic [7:0] model_vec();
    return {2'b00, m_commit, m_locked, ~m_locked, m_req, m_err};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic       smp;
    logic       evt;
    logic [1:0] mode;
    smp   = m_evt_d;
    mode  = vinfo_i[1:0];
    evt   = !nDSYNC && Sync_pre[3] && !Sync_cur[3];
    m_err = 1'b0;
    if (!nRST) begin
      m_evt_d = 0; m_req = 0; m_locked = 0; m_cand = 0; m_commit = 0;
      m_run = 0; m_waits = 0; m_silent = 0;
      return;
    end
    if (m_silent >= 7) begin
      m_locked = 0; m_req = 0; m_run = 0;
    end else if (m_req) begin
      if (cfg_ack_i) begin
        m_commit = m_cand; m_req = 0; m_locked = 1;
      end else if (smp && mode != m_cand) begin
        m_req = 0; m_cand = mode; m_run = 1;
      end else if (smp) begin
        m_waits++;
`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
        if (m_waits == ACK_TO_FRAMES) begin
          m_err = 1; m_req = 0; m_run = 0;
        end
`endif
      end
    end else if (m_locked) begin
      if (smp && mode != m_commit) begin
        m_locked = 0; m_cand = mode; m_run = 1;
      end
    end else if (smp) begin
      if (m_run > 0 && mode == m_cand) m_run++;
      else begin
        m_cand = mode; m_run = 1;
      end
      if (m_run == LOCK_FRAMES) begin
        m_req = 1; m_waits = 0;
      end
    end
    m_evt_d  = evt;
    m_silent = nDSYNC ? ((m_silent < 100) ? m_silent + 1 : m_silent) : 0;
  endtask

  task automatic drive_ack();
    case (ack_pol)
      0:       cfg_ack_i = 1'b0;
      1:       cfg_ack_i = ($urandom_range(0, 99) < 30);
      2:       cfg_ack_i = (req_age >= 2);
      default: cfg_ack_i = m_req && m_evt_d;
    endcase
  endtask

  task automatic tick();
    drive_ack();
    model_step();
    @(posedge VCLK);
    #1;
    check("outs", dut_vec(), model_vec());
    req_age = m_req ? req_age + 1 : 0;
    if (cfg_req_o) saw_req = 1'b1;
    if (cfg_err_o) err_seen++;
  endtask

  // One frame: a vsync event on the first data word, mode valid only on the
  // following (sample) cycle, junk vinfo everywhere else.
  task automatic send_frame(input logic [1:0] mode, input int words);
    logic cur3;
    for (int w = 0; w < words; w++) begin
      for (int c = 0; c < 4; c++) begin
        nDSYNC   = (c != 0);
        cur3     = (c == 0) ? (w != 0) : 1'($urandom_range(0, 1));
        Sync_pre = {1'b1, 3'($urandom_range(0, 7))};
        Sync_cur = {cur3, 3'($urandom_range(0, 7))};
        vinfo_i  = (w == 0 && c == 1) ? {2'($urandom_range(0, 3)), mode}
                                      : 4'($urandom_range(0, 15));
        tick();
      end
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      nDSYNC   = 1'b1;
      Sync_pre = 4'($urandom_range(0, 15));
      Sync_cur = 4'($urandom_range(0, 15));
      vinfo_i  = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    logic [1:0] cur_mode;
    nRST = 1'b0; nDSYNC = 1'b1; Sync_pre = 4'hF; Sync_cur = 4'hF;
    vinfo_i = 4'h0; cfg_ack_i = 1'b0;
    m_evt_d = 0; m_req = 0; m_locked = 0; m_err = 0; m_cand = 0; m_commit = 0;
    m_run = 0; m_waits = 0; m_silent = 0;
    tick();
    tick();
    check("reset", dut_vec(), 8'b0000_0100);
    nRST = 1'b1;

    // Clean NTSC 240p lock, ack two cycles after request
    ack_pol = 2;
    repeat (6) send_frame(2'b00, 2);
    check("lock00", dut_vec(), 8'b0000_1000);

    // Flicker during qualification
    do_reset();
    saw_req = 1'b0;
    send_frame(2'b00, 2); send_frame(2'b00, 2);
    send_frame(2'b10, 2); send_frame(2'b10, 2); send_frame(2'b10, 2);
    check("flick_noreq", {7'd0, saw_req}, 8'h00);
    send_frame(2'b10, 2);
    check("flick_lock10", dut_vec(), 8'b0010_1000);

    // Mode change while locked
    do_reset();
    repeat (6) send_frame(2'b00, 2);
    ack_pol = 0;
    repeat (4) send_frame(2'b01, 2);
    check("chg_pending", dut_vec(), 8'b0000_0110);
    ack_pol = 2;
    send_frame(2'b01, 2);
    check("chg_lock01", dut_vec(), 8'b0001_1000);

    // nDSYNC loss: 3 high cycles at the end of the frame + 5 more
    gap(5);
    check("dsync_loss", dut_vec(), 8'b0001_0100);

    // Reset in RECONF
    ack_pol = 0;
    repeat (4) send_frame(2'b10, 2);
    check("rcf_pending", dut_vec(), 8'b0001_0110);
    do_reset();
    check("rcf_reset", dut_vec(), 8'b0000_0100);

    // Ack together with a mismatched sample: commit wins
    repeat (4) send_frame(2'b00, 2);
    check("sim_pending", dut_vec(), 8'b0000_0110);
    ack_pol = 3;
    send_frame(2'b10, 2);
    check("sim_commit", dut_vec(), 8'b0000_1000);

`ifdef VINFO_CTRL_ACK_TIMEOUT_EN
    // Ack timeout and re-qualification
    ack_pol = 0;
    repeat (4) send_frame(2'b11, 2);
    err_seen = 0;
    repeat (3) send_frame(2'b11, 2);
    check("to_err", 8'(err_seen), 8'd1);
    repeat (4) send_frame(2'b11, 2);
    check("to_rereq", dut_vec(), 8'b0000_0110);
`endif

    // Randomized frame streams
    cur_mode = 2'b00;
    for (int f = 0; f < 300; f++) begin
      if (f % 10 == 0) ack_pol = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 25) cur_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4)  gap($urandom_range(1, 8));
      if ($urandom_range(0, 99) < 2)  do_reset();
      send_frame(cur_mode, $urandom_range(2, 5));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/n64_vinfo_ctrl.md
# n64_vinfo_ctrl

Video-mode lock controller between the video-info extractor and the mode-dependent datapath stages (demux, deblur, sync/timing generation). It qualifies the extracted `{vmode, n64_480i}` pair over consecutive frames and sequences a request/acknowledge reconfiguration of downstream logic. It holds downstream stages blanked until a stable mode is committed, and drops lock on mode change or loss of nDSYNC.

## Interface
- `LOCK_FRAMES`, 4: consecutive identical frame samples required to commit a mode; legal range 1..15.
- `ACK_TO_FRAMES`, 3: frame samples allowed in RECONF without ack before abort; legal range 1..15; used only with the timeout feature.
- `VCLK  in  1`: video clock; all logic is on its rising edge.
- `nRST  in  1`: reset, synchronous, active-low.
- `nDSYNC  in  1`: data sync; low once per 4-cycle data word.
- `Sync_pre  in  4`: previous sync nibble; bit3 = nVSYNC.
- `Sync_cur  in  4`: current sync nibble; bit3 = nVSYNC.
- `vinfo_i  in  4`: `{data_cnt[1:0], vmode, n64_480i}` from the extractor.
- `cfg_ack_i  in  1`: downstream reconfiguration done; level-sampled.
- `vmode_o  out  1`: committed mode; 1 = PAL, 0 = NTSC.
- `n64_480i_o  out  1`: committed scan type; 1 = 480i/576i.
- `locked_o  out  1`: high in LOCKED only.
- `blank_o  out  1`: high in every state except LOCKED.
- `cfg_req_o  out  1`: reconfiguration request; high throughout RECONF.
- `cfg_err_o  out  1`: one-cycle pulse on ack timeout.

## Operation
- `frame_evt = !nDSYNC & Sync_pre[3] & !Sync_cur[3]`.
- Sample point `smp` is `frame_evt` delayed one VCLK, because the extractor updates `vinfo_i` on the event cycle.
- Sampled pair: `mode = vinfo_i[1:0]`. The `data_cnt` bits are ignored.
- Registers:
  - `cand[1:0]`: candidate mode.
  - `qcnt`: 4 bits, saturating at LOCK_FRAMES.
  - `tcnt`: 4 bits.
  - `wd`: 3-bit nDSYNC watchdog.
- State machine:
  - UNLOCKED: on `smp`, set `cand <= mode` and `qcnt <= 1`. Go to RECONF if LOCK_FRAMES == 1, otherwise go to QUALIFY.
  - QUALIFY, `smp` with `mode == cand`: `qcnt++`. When the incremented value equals LOCK_FRAMES, go to RECONF and set `tcnt <= 0`.
  - QUALIFY, `smp` with `mode != cand`: set `cand <= mode` and `qcnt <= 1`; stay in QUALIFY.
  - RECONF, `cfg_ack_i` high: set `{vmode_o, n64_480i_o} <= cand` and go to LOCKED. Ack has priority over any same-cycle `smp` or timeout.
  - RECONF, `smp` with `mode != cand`: abort without commit. Set `cand <= mode`, `qcnt <= 1`, go to QUALIFY.
  - RECONF, `smp` with `mode == cand`: `tcnt++` (timeout feature only).
  - LOCKED, `smp` with `mode != {vmode_o, n64_480i_o}`: go to QUALIFY with `cand <= mode` and `qcnt <= 1`. The committed outputs keep their old values.
- Watchdog: `wd` clears when nDSYNC is low and increments otherwise. At `wd == 7`, from any state, go to UNLOCKED and clear `qcnt`. The committed outputs are retained.
- `cfg_ack_i` outside RECONF is ignored.

## Timing
- Reset values (nRST low at a VCLK edge):
  - State is UNLOCKED.
  - `vmode_o = 0`, `n64_480i_o = 0`, `locked_o = 0`, `blank_o = 1`, `cfg_req_o = 0`, `cfg_err_o = 0`.
  - `cand = 0`, `qcnt = 0`, `tcnt = 0`, `wd = 0`, `smp` pipeline cleared.
- Reset mid-RECONF drops `cfg_req_o` the next cycle and discards the pending commit.
- All outputs are registered and are decoded from the state register.
  - Transition on edge N → outputs change after edge N.
  - `cfg_req_o` rises the cycle after the qualifying `smp`.
- Ack handling:
  - Ack sampled at edge N → `cfg_req_o` low, `locked_o`/`blank_o` updated, and committed mode outputs valid, all after edge N.
  - Downstream must not drop `cfg_ack_i` requirements on `cfg_req_o` falling; ack is a level.
- Lock latency from a clean start: LOCK_FRAMES samples, plus 1 cycle to RECONF, plus ack latency.
- Watchdog fires 7 cycles after the last nDSYNC low, so normal 4-cycle cadence never triggers it.

## Configuration
- `VINFO_CTRL_ACK_TIMEOUT_EN` defined:
  - In RECONF, when the incremented `tcnt` reaches ACK_TO_FRAMES, pulse `cfg_err_o` for one cycle.
  - Go to UNLOCKED and drop `cfg_req_o` the same cycle as the pulse.
- Undefined:
  - `tcnt` is not built.
  - RECONF waits indefinitely for ack or a mode change.
  - `cfg_err_o` is tied 0.

## Test plan
- **Clean NTSC 240p lock:** 6 frames with vinfo mode 2'b00, LOCK_FRAMES = 4, ack 2 cycles after req → `cfg_req_o` rises 1 cycle after the 4th `smp`; then `locked_o = 1`, `blank_o = 0`, `vmode_o = 0`, `n64_480i_o = 0`.
- **Mode flicker in QUALIFY:** frame sequence 00, 00, 10, 10, 10, 10 → no req before the 6th `smp`; then commit `vmode_o = 1`, `n64_480i_o = 0`.
- **Change while LOCKED:** locked at 00, then mode 01 for 4 frames → `blank_o` rises 1 cycle after the first mismatched `smp`; `vmode_o`/`n64_480i_o` stay 0/0 until the new ack, then commit 0/1.
- **nDSYNC loss:** hold nDSYNC high for 8 cycles while LOCKED → UNLOCKED after cycle 7 (`locked_o = 0`, `blank_o = 1`); committed outputs unchanged.
- **Ack timeout (feature on), ACK_TO_FRAMES = 3:** no ack for 3 matching `smp` → single-cycle `cfg_err_o`, `cfg_req_o` low the same cycle, re-qualify, next req after 4 more frames.
- **Reset and simultaneous events:** nRST low during RECONF → all reset values next cycle. Ack and mismatched `smp` in the same cycle → commit of `cand` wins, and LOCKED is entered.
